fir_out_decimator: RTL and testbench
====================================

# fir_out_decimator

Downstream stage of the FIR filter. It takes the 32-bit accumulator result `y_out` and its per-sample strobe, then decimates by `DECIM`. Each kept sample is rounded, arithmetically shifted and saturated to `OUT_W` bits. Results are buffered in a small FIFO and presented on a valid/ready stream to the next consumer.

## Interface
Parameters:
- `IN_W`, 32, input sample width (signed)
- `OUT_W`, 16, output sample width (signed)
- `SHIFT`, 15, right-shift amount (Q-format renormalisation), 0..IN_W-1
- `DECIM`, 4, keep 1 of every `DECIM` input samples, ≥1
- `DEPTH`, 4, output FIFO depth, power of two ≥2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous flush; empties FIFO, resets phase, clears sticky flags
- `y_in`  in  IN_W  signed filter output
- `y_valid`  in  1  one-cycle strobe, `y_in` valid this cycle; driven high the cycle after the filter's `start`
- `out_data`  out  OUT_W  signed FIFO head (show-ahead)
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid & out_ready`
- `sat_sticky`  out  1  set when any kept sample saturated
- `drop_sticky`  out  1  set when any kept sample was lost to a full FIFO

## Operation
- Reset (`rst`=0) forces these values: phase=0, FIFO empty, `out_valid`=0, `out_data`=0, both sticky flags 0, stage-1 valid 0.
- Phase counter counts 0..DECIM-1 and advances on each `y_valid`, wrapping to 0.
- A sample is kept only when `y_valid` and phase==0. With `DECIM`=1 every sample is kept.
- Stage 1 (registered):
  - Form an IN_W+1-bit sum: sign-extended `y_in` + 2^(SHIFT-1). When SHIFT=0 the addend is 0.
  - Arithmetic-shift the sum right by SHIFT.
  - Rounding is round-half-up toward +inf.
- Stage 2 (combinational into the FIFO write):
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - If the clamp changes the value, set `sat_sticky`.
  - Push the clamped value into the FIFO.
- Push arbitration:
  - Push while full with no pop in the same cycle: sample discarded, `drop_sticky` set.
  - Push while full with a pop in the same cycle: push accepted, count unchanged.
  - Push and pop when not full: both proceed, count unchanged.
- Pop occurs on `out_valid & out_ready`. `out_ready` while empty has no effect.
- Output order is strictly FIFO. `out_data` is stable while `out_valid & !out_ready`.
- `clear` has priority over push and pop in the same cycle:
  - Stage-1 contents are discarded.
  - Phase returns to 0.
  - Sticky flags are cleared.
- Sticky flags hold until `clear` or reset.

## Timing
- Latency: `y_valid` sampled at edge k; stage-1 register loads at edge k; FIFO write at edge k+1. If the FIFO was empty, `out_valid`=1 and `out_data` are valid after edge k+1.
- Throughput: one kept sample per cycle sustained while `out_ready`=1. No bubbles with back-to-back `y_valid`.
- `rst` asserted mid-operation clears all state immediately, regardless of `clk`. Deassertion is expected to be synchronised externally.
- `clear` takes effect at the next edge. `out_valid`=0 the cycle after, even if stage 1 held a sample.
- Flags rise in the cycle after the offending write edge.

## Structure
- Shared package `fir_pkg` holds:
  - default widths `FIR_IN_W`=32 and `FIR_OUT_W`=16
  - `FIR_SHIFT`
  - the signed sample typedefs shared with the FIR filter
- One sub-module: `fir_sample_fifo`.
  - Synchronous, show-ahead FIFO parameterised by width and depth.
  - Pointers carry one extra wrap bit.
  - Ports: `full`, `empty`, push, pop, clear.
- Phase counter, rounding/saturation and flags live in the top.

## Test plan
All scenarios use SHIFT=15, DECIM=1 unless stated.
1. Reset: hold `rst`=0 with random inputs. Expect `out_valid`=0, `out_data`=0, both flags 0. Release; still idle.
2. Rounding: drive `y_in` = 16384, 16383, -16384, -16385 with `out_ready`=1. Expect outputs 1, 0, 0, -1, each 2 edges after its strobe. No flags.
3. Saturation: drive 0x7FFF_FFFF, then 0x8000_0000. Expect 32767, then -32768. `sat_sticky`=1 after the first. `clear` returns the flag to 0.
4. Decimation: DECIM=4, drive 8 strobes of k·32768 for k=1..8. Expect exactly two outputs, 1 and 5.
5. Backpressure: DEPTH=4, `out_ready`=0, 5 kept samples 1..5 (×32768).
   - Expect `out_valid`=1 with `out_data`=1 held stable; `drop_sticky`=1 after the 5th.
   - Then `out_ready`=1: expect 1, 2, 3, 4 on consecutive cycles, then `out_valid`=0.
6. Full with simultaneous pop: FIFO full, `out_ready`=1 and a kept strobe in the same cycle. Expect no drop and the new sample delivered last.
7. Reset mid-stream: pull `rst` low for 1 cycle with 3 entries queued. Expect `out_valid`=0 immediately. The phase restarts, so the next strobe is kept.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR definitions: default sample widths, renormalisation shift and
// the signed sample types used on both sides of the filter.
package fir_pkg;

    localparam int FIR_IN_W  = 32;
    localparam int FIR_OUT_W = 16;
    localparam int FIR_SHIFT = 15;

    typedef logic signed [FIR_IN_W-1:0]  fir_acc_t;
    typedef logic signed [FIR_OUT_W-1:0] fir_sample_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous show-ahead FIFO. The pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate occupancy counter.
module fir_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        // A pop in the same cycle frees the slot the push is about to use.
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
        rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fir_out_decimator.sv
// FIR output stage: decimate, round-half-up with arithmetic shift, saturate,
// then buffer kept samples in a FIFO behind a valid/ready stream.
module fir_out_decimator
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = FIR_SHIFT,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic signed [IN_W-1:0]  y_in,
    input  logic                    y_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_sticky,
    output logic                    drop_sticky
);

    localparam int PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [PH_W-1:0]     PH_LAST = PH_W'(DECIM - 1);
    localparam logic signed [IN_W:0] RND    =
        (SHIFT > 0) ? ({{IN_W{1'b0}}, 1'b1} << RND_POS) : '0;
    localparam logic signed [IN_W:0] MAXV   =
        {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] MINV   =
        {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic [PH_W-1:0]       phase;
    logic                  keep;
    logic signed [IN_W:0]  sum_ext;
    logic signed [IN_W:0]  rounded;
    logic                  s1_valid;
    logic signed [IN_W:0]  s1_data;
    logic                  over;
    logic                  under;
    logic [OUT_W-1:0]      clamped;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [OUT_W-1:0]      head;

    always_comb begin
        keep    = y_valid && (phase == '0);
        // One guard bit keeps the rounding addend from overflowing the input range.
        sum_ext = $signed({y_in[IN_W-1], y_in}) + RND;
        rounded = sum_ext >>> SHIFT;
        over    = s1_data > MAXV;
        under   = s1_data < MINV;
        if (over) begin
            clamped = MAXV[OUT_W-1:0];
        end else if (under) begin
            clamped = MINV[OUT_W-1:0];
        end else begin
            clamped = s1_data[OUT_W-1:0];
        end
        out_valid = !empty;
        out_data  = $signed(head);
        pop       = out_valid && out_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (y_valid) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= keep && !clear;
            if (keep) s1_data <= rounded;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_sticky  <= 1'b0;
            drop_sticky <= 1'b0;
        end else if (clear) begin
            sat_sticky  <= 1'b0;
            drop_sticky <= 1'b0;
        end else begin
            if (s1_valid && (over || under)) sat_sticky <= 1'b1;
            if (s1_valid && full && !pop)    drop_sticky <= 1'b1;
        end
    end

    fir_sample_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (s1_valid),
        .pop   (pop),
        .wdata (clamped),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_fir_out_decimator.sv
// Bench for fir_out_decimator: one instance with DECIM=1 and one with DECIM=4
// share the stimulus and are both checked against a queue-based reference.
module tb_fir_out_decimator;

    localparam int S     = 15;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic signed [31:0] y_in;
    logic               y_valid;
    logic               out_ready;

    logic signed [15:0] u1_data;
    logic               u1_valid, u1_sat, u1_drop;
    logic signed [15:0] u4_data;
    logic               u4_valid, u4_sat, u4_drop;

    int total = 0;
    int bad   = 0;

    // Reference state, index 0 = DECIM 1, index 1 = DECIM 4.
    longint mq [2][$];
    bit     mpv   [2];
    longint mpval [2];
    int     mph   [2];
    bit     msat  [2];
    bit     mdrop [2];

    always #5 clk = ~clk;

    fir_out_decimator #(
        .IN_W (32), .OUT_W (16), .SHIFT (S), .DECIM (1), .DEPTH (DEPTH)
    ) u1 (
        .clk (clk), .rst (rst), .clear (clear), .y_in (y_in), .y_valid (y_valid),
        .out_data (u1_data), .out_valid (u1_valid), .out_ready (out_ready),
        .sat_sticky (u1_sat), .drop_sticky (u1_drop)
    );

    fir_out_decimator #(
        .IN_W (32), .OUT_W (16), .SHIFT (S), .DECIM (4), .DEPTH (DEPTH)
    ) u4 (
        .clk (clk), .rst (rst), .clear (clear), .y_in (y_in), .y_valid (y_valid),
        .out_data (u4_data), .out_valid (u4_valid), .out_ready (out_ready),
        .sat_sticky (u4_sat), .drop_sticky (u4_drop)
    );

    function automatic longint round_shift(input logic signed [31:0] y);
        longint v;
        v = longint'(y) + (longint'(1) <<< (S - 1));
        return v >>> S;
    endfunction

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            mpv[d] = 1'b0; mph[d] = 0; msat[d] = 1'b0; mdrop[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int decim;
        longint c;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            decim = (d == 0) ? 1 : 4;
            if (clear) begin
                mq[d].delete();
                mpv[d] = 1'b0; mph[d] = 0; msat[d] = 1'b0; mdrop[d] = 1'b0;
            end else begin
                if (mq[d].size() > 0 && out_ready) void'(mq[d].pop_front());
                if (mpv[d]) begin
                    c = sat16(mpval[d]);
                    if (c != mpval[d]) msat[d] = 1'b1;
                    if (mq[d].size() < DEPTH) mq[d].push_back(c);
                    else mdrop[d] = 1'b1;
                end
                mpv[d]   = y_valid && (mph[d] == 0);
                mpval[d] = round_shift(y_in);
                if (y_valid) mph[d] = (mph[d] + 1) % decim;
            end
        end
    endtask

    task automatic check_all(input string tag);
        longint h1, h4;
        h1 = (mq[0].size() > 0) ? mq[0][0] : 0;
        h4 = (mq[1].size() > 0) ? mq[1][0] : 0;
        chk({tag, ".u1.valid"}, longint'(u1_valid), longint'(mq[0].size() > 0));
        chk({tag, ".u1.data"},  longint'(u1_data),  h1);
        chk({tag, ".u1.sat"},   longint'(u1_sat),   longint'(msat[0]));
        chk({tag, ".u1.drop"},  longint'(u1_drop),  longint'(mdrop[0]));
        chk({tag, ".u4.valid"}, longint'(u4_valid), longint'(mq[1].size() > 0));
        chk({tag, ".u4.data"},  longint'(u4_data),  h4);
        chk({tag, ".u4.sat"},   longint'(u4_sat),   longint'(msat[1]));
        chk({tag, ".u4.drop"},  longint'(u4_drop),  longint'(mdrop[1]));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drv(input bit v, input logic signed [31:0] y, input bit rdy, input bit clr);
        y_valid = v; y_in = y; out_ready = rdy; clear = clr;
    endtask

    initial begin
        logic signed [31:0] rin [4];
        longint             rexp [4];
        longint             got [$];
        int                 sel;

        rin  = '{32'sd16384, 32'sd16383, -32'sd16384, -32'sd16385};
        rexp = '{1, 0, 0, -1};

        // Reset with random inputs, then release and stay idle.
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drv(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            step("reset");
        end
        chk("reset.u1.valid_lit", longint'(u1_valid), 0);
        chk("reset.u1.data_lit", longint'(u1_data), 0);
        rst = 1'b1;
        drv(0, 0, 0, 0);
        step("idle");
        step("idle");

        // Rounding, back-to-back strobes, consumer always ready.
        for (int i = 0; i < 4; i++) begin
            drv(1, rin[i], 1, 0);
            step("round");
            if (i > 0) chk("round.lit", longint'(u1_data), rexp[i-1]);
        end
        drv(0, 0, 1, 0);
        step("round");
        chk("round.lit", longint'(u1_data), rexp[3]);
        step("round");
        chk("round.nosat", longint'(u1_sat), 0);

        // Saturation at both rails, then clear.
        drv(1, 32'sh7FFF_FFFF, 1, 0);
        step("sat");
        drv(1, 32'sh8000_0000, 1, 0);
        step("sat");
        chk("sat.hi", longint'(u1_data), 32767);
        chk("sat.flag", longint'(u1_sat), 1);
        drv(0, 0, 1, 0);
        step("sat");
        chk("sat.lo", longint'(u1_data), -32768);
        drv(0, 0, 1, 1);
        step("sat.clear");
        drv(0, 0, 1, 0);
        chk("sat.cleared", longint'(u1_sat), 0);

        // Decimation by 4 on the second instance.
        got.delete();
        for (int j = 0; j < 12; j++) begin
            if (j < 8) drv(1, 32'((j + 1) * 32768), 1, 0);
            else drv(0, 0, 1, 0);
            step("decim");
            if (u4_valid) got.push_back(longint'(u4_data));
        end
        chk("decim.count", longint'(got.size()), 2);
        chk("decim.first", (got.size() > 0) ? got[0] : -999, 1);
        chk("decim.second", (got.size() > 1) ? got[1] : -999, 5);

        // Backpressure: five kept samples into a four-deep FIFO.
        drv(0, 0, 0, 1);
        step("bp.clear");
        for (int k = 1; k <= 5; k++) begin
            drv(1, 32'(k * 32768), 0, 0);
            step("bp.fill");
            if (k > 1) chk("bp.hold", longint'(u1_data), 1);
        end
        drv(0, 0, 0, 0);
        step("bp.fill");
        step("bp.fill");
        chk("bp.drop", longint'(u1_drop), 1);
        drv(0, 0, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            chk("bp.drain.valid", longint'(u1_valid), 1);
            chk("bp.drain.data", longint'(u1_data), k);
            step("bp.drain");
        end
        chk("bp.empty", longint'(u1_valid), 0);

        // Full FIFO with a push and a pop in the same cycle.
        drv(0, 0, 0, 1);
        step("fp.clear");
        for (int k = 10; k <= 14; k++) begin
            drv(1, 32'(k * 32768), 0, 0);
            step("fp.fill");
        end
        drv(0, 0, 1, 0);
        got.delete();
        for (int j = 0; j < 8; j++) begin
            if (u1_valid) got.push_back(longint'(u1_data));
            step("fp.drain");
        end
        chk("fp.count", longint'(got.size()), 5);
        chk("fp.first", (got.size() > 0) ? got[0] : -999, 10);
        chk("fp.last", (got.size() > 4) ? got[4] : -999, 14);
        chk("fp.nodrop", longint'(u1_drop), 0);

        // Asynchronous reset with three entries queued.
        drv(0, 0, 0, 1);
        step("rm.clear");
        for (int k = 1; k <= 3; k++) begin
            drv(1, 32'(k * 32768), 0, 0);
            step("rm.fill");
        end
        drv(0, 0, 0, 0);
        step("rm.fill");
        chk("rm.queued", longint'(u1_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rm.async.u1", longint'(u1_valid), 0);
        chk("rm.async.u4", longint'(u4_valid), 0);
        step("rm.low");
        rst = 1'b1;
        drv(1, 32'(7 * 32768), 1, 0);
        step("rm.restart");
        drv(0, 0, 1, 0);
        step("rm.restart");
        chk("rm.u1.data", longint'(u1_data), 7);
        chk("rm.u4.valid", longint'(u4_valid), 1);
        chk("rm.u4.data", longint'(u4_data), 7);
        step("rm.restart");

        // Randomised traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: y_in = $urandom;
                1: y_in = 32'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
                2: y_in = 32'(32767 * 32768 + int'($urandom_range(0, 65535)) - 32768);
                default: y_in = 32'(-32768 * 32768 + int'($urandom_range(0, 65535)) - 32768);
            endcase
            y_valid   = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            clear     = ($urandom_range(0, 99) < 3);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
